// File: rtl/alien_depth_sorter_if.sv
// Bus bundle between the frame-data source, the depth sorter and the renderer.
//   frame_start  : one-cycle sort request (vblank start)
//   obj_active   : per-object active bits
//   obj_r        : packed distances, object k at [k*R_BITS +: R_BITS]
//   obj_quadrant : packed quadrants, object k at [k*2 +: 2]
//   busy         : sort in progress
//   done         : one-cycle pulse when a new list is published
//   list_valid   : a list has been published since reset
//   order_count  : number of entries in the published list
//   order_idx    : published list, slot s at [s*IDX_W +: IDX_W], slot 0 nearest
interface alien_depth_sorter_if #(
    parameter int unsigned OBJ_LIMIT = 16,
    parameter int unsigned R_BITS    = 4
);
    localparam int unsigned IDX_W = $clog2(OBJ_LIMIT);
    localparam int unsigned CNT_W = $clog2(OBJ_LIMIT + 1);

    logic                         frame_start;
    logic [OBJ_LIMIT-1:0]         obj_active;
    logic [OBJ_LIMIT*R_BITS-1:0]  obj_r;
    logic [OBJ_LIMIT*2-1:0]       obj_quadrant;
    logic                         busy;
    logic                         done;
    logic                         list_valid;
    logic [CNT_W-1:0]             order_count;
    logic [OBJ_LIMIT*IDX_W-1:0]   order_idx;

    modport master (
        output frame_start, obj_active, obj_r, obj_quadrant,
        input  busy, done, list_valid, order_count, order_idx
    );

    modport slave (
        input  frame_start, obj_active, obj_r, obj_quadrant,
        output busy, done, list_valid, order_count, order_idx
    );
endinterface

// File: rtl/alien_depth_sorter.sv
// Per-frame counting sort of this quadrant's aliens, nearest-first by distance,
// ties to the lower object index. The list is published atomically at COMMIT.
//   clk : pixel clock
//   rst : asynchronous active-low reset
//   bus : alien_depth_sorter_if slave (request/table in, ordered list out)
module alien_depth_sorter #(
    parameter int unsigned OBJ_LIMIT = 16,
    parameter int unsigned QUADRANT  = 0,
    parameter int unsigned R_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alien_depth_sorter_if.slave  bus
);
    localparam int unsigned IDX_W    = $clog2(OBJ_LIMIT);
    localparam int unsigned CNT_W    = $clog2(OBJ_LIMIT + 1);
    localparam int unsigned NB       = 1 << R_BITS;
    localparam int unsigned STEP_MAX = (OBJ_LIMIT > NB) ? OBJ_LIMIT : NB;
    localparam int unsigned STEP_W   = $clog2(STEP_MAX);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_PREFIX, S_PLACE, S_COMMIT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [STEP_W-1:0]           r_step;
    logic                        w_start;

    logic [OBJ_LIMIT-1:0]        r_snap_act;
    logic [OBJ_LIMIT*R_BITS-1:0] r_snap_r;
    logic [OBJ_LIMIT*2-1:0]      r_snap_q;
    logic [CNT_W-1:0]            r_hist   [NB];
    logic [CNT_W-1:0]            r_base   [NB];
    logic [IDX_W-1:0]            r_shadow [OBJ_LIMIT];
    logic [CNT_W-1:0]            r_sum;

    logic                        r_busy;
    logic                        r_done;
    logic                        r_list_valid;
    logic [CNT_W-1:0]            r_order_count;
    logic [OBJ_LIMIT*IDX_W-1:0]  r_order_idx;

    logic [IDX_W-1:0]            w_idx;
    logic [R_BITS-1:0]           w_bkt;
    logic [R_BITS-1:0]           w_obj_r;
    logic                        w_elig;
    logic                        w_last_obj;
    logic                        w_last_bkt;

    // Scan pointer doubles as object index (COUNT/PLACE) and bucket index (PREFIX).
    assign w_idx      = IDX_W'(r_step);
    assign w_bkt      = R_BITS'(r_step);
    assign w_obj_r    = r_snap_r[int'(w_idx)*R_BITS +: R_BITS];
    assign w_elig     = r_snap_act[w_idx] && (r_snap_q[int'(w_idx)*2 +: 2] == 2'(QUADRANT));
    assign w_last_obj = (r_step == STEP_W'(OBJ_LIMIT - 1));
    assign w_last_bkt = (r_step == STEP_W'(NB - 1));

    // Next-state logic; requests outside IDLE are dropped, not queued.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT:  if (w_last_obj) w_state_nxt = S_PREFIX;
            S_PREFIX: if (w_last_bkt) w_state_nxt = S_PLACE;
            S_PLACE:  if (w_last_obj) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register and phase step counter (restarts on every phase change).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= (w_state_nxt != r_state) ? '0 : r_step + STEP_W'(1);
        end
    end

    // Snapshot, histogram, prefix, placement and publish datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_act    <= '0;
            r_snap_r      <= '0;
            r_snap_q      <= '0;
            r_sum         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_list_valid  <= 1'b0;
            r_order_count <= '0;
            r_order_idx   <= '0;
            for (int b = 0; b < int'(NB); b++) begin
                r_hist[b] <= '0;
                r_base[b] <= '0;
            end
            for (int s = 0; s < int'(OBJ_LIMIT); s++) r_shadow[s] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_snap_act <= bus.obj_active;
                        r_snap_r   <= bus.obj_r;
                        r_snap_q   <= bus.obj_quadrant;
                        r_sum      <= '0;
                        r_busy     <= 1'b1;
                        for (int b = 0; b < int'(NB); b++) r_hist[b] <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_elig) r_hist[w_obj_r] <= r_hist[w_obj_r] + CNT_W'(1);
                end
                S_PREFIX: begin
                    // Exclusive prefix: bucket start slot, then accumulate.
                    r_base[w_bkt] <= r_sum;
                    r_sum         <= r_sum + r_hist[w_bkt];
                end
                S_PLACE: begin
                    if (w_elig) begin
                        r_shadow[IDX_W'(r_base[w_obj_r])] <= w_idx;
                        r_base[w_obj_r] <= r_base[w_obj_r] + CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    // Stale shadow entries beyond the count are zeroed on publish.
                    for (int s = 0; s < int'(OBJ_LIMIT); s++)
                        r_order_idx[s*IDX_W +: IDX_W] <= (CNT_W'(s) < r_sum) ? r_shadow[s] : '0;
                    r_order_count <= r_sum;
                    r_list_valid  <= 1'b1;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.list_valid  = r_list_valid;
    assign bus.order_count = r_order_count;
    assign bus.order_idx   = r_order_idx;
endmodule

// File: tb/tb_alien_depth_sorter.sv
// Directed bench for alien_depth_sorter: table of frame tables with hand-sorted
// expected lists, plus sequences for snapshot, ignored requests and abort.
module tb_alien_depth_sorter;
    localparam int unsigned OBJ_LIMIT = 16;
    localparam int unsigned R_BITS    = 4;
    localparam int          LAT       = 2*16 + 16 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alien_depth_sorter_if #(.OBJ_LIMIT(OBJ_LIMIT), .R_BITS(R_BITS)) bus ();

    alien_depth_sorter #(.OBJ_LIMIT(OBJ_LIMIT), .QUADRANT(0), .R_BITS(R_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] act;
        logic [63:0] r;
        logic [31:0] quad;
        logic [4:0]  exp_cnt;
        logic [63:0] exp_idx;
    } vec_t;

    vec_t vecs [7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.obj_active   = v.act;
        bus.obj_r        = v.r;
        bus.obj_quadrant = v.quad;
    endtask

    // Pulse frame_start for one edge, then wait (bounded) for done; lat=0 on timeout.
    task automatic run_sort(input string nm, output int lat);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        chk({nm, ".busy_start"}, 64'(bus.busy), 64'd1);
        lat = 0;
        for (int n = 1; n <= LAT + 20; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        chk({nm, ".latency"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        int lat;
        int dones;
        int first;

        bus.frame_start  = 1'b0;
        bus.obj_active   = '0;
        bus.obj_r        = '0;
        bus.obj_quadrant = '0;

        vecs[0] = '{"empty",    16'h0000, 64'h0000_0000_0000_0000, 32'h0000_0000, 5'd0,  64'h0};
        vecs[1] = '{"order",    16'h000F, 64'h0000_0000_0000_2F29, 32'h0000_0000, 5'd4,  64'h2031};
        vecs[2] = '{"quadflt",  16'h002F, 64'h0000_0000_0000_2F29, 32'h0000_0400, 5'd4,  64'h2031};
        vecs[3] = '{"fullbkt",  16'hFFFF, 64'h7777_7777_7777_7777, 32'h0000_0000, 5'd16, 64'hFEDC_BA98_7654_3210};
        vecs[4] = '{"reverse",  16'hFFFF, 64'h0123_4567_89AB_CDEF, 32'h0000_0000, 5'd16, 64'h0123_4567_89AB_CDEF};
        vecs[5] = '{"otherq",   16'hFFFF, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFFF, 5'd0,  64'h0};
        vecs[6] = '{"sparse",   16'h8421, 64'h0000_0100_0030_0003, 32'h0000_0000, 5'd4,  64'h50AF};

        // Reset held for three cycles.
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst.busy",  64'(bus.busy), 64'd0);
        chk("rst.done",  64'(bus.done), 64'd0);
        chk("rst.valid", 64'(bus.list_valid), 64'd0);
        chk("rst.count", 64'(bus.order_count), 64'd0);
        chk("rst.idx",   64'(bus.order_idx), 64'd0);

        // Table-driven sorts.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            run_sort(vecs[i].name, lat);
            chk({vecs[i].name, ".count"}, 64'(bus.order_count), 64'(vecs[i].exp_cnt));
            chk({vecs[i].name, ".idx"},   64'(bus.order_idx),   vecs[i].exp_idx);
            chk({vecs[i].name, ".valid"}, 64'(bus.list_valid),  64'd1);
            chk({vecs[i].name, ".busy"},  64'(bus.busy),        64'd0);
            @(posedge clk); #1;
            chk({vecs[i].name, ".done_1cyc"}, 64'(bus.done), 64'd0);
        end

        // Snapshot isolation, request during sort, request in COMMIT cycle.
        apply(vecs[1]);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        bus.obj_r[4 +: 4] = 4'hF;
        dones = 0;
        first = 0;
        for (int n = 1; n <= LAT + 20; n++) begin
            @(posedge clk); #1;
            bus.frame_start = (n == 9) || (n == 48);
            if (n == LAT) chk("snap.busy_commit_req", 64'(bus.busy), 64'd0);
            if (bus.done) begin
                dones++;
                if (first == 0) first = n;
            end
        end
        bus.frame_start = 1'b0;
        chk("snap.done_pulses", 64'(dones), 64'd1);
        chk("snap.latency",     64'(first), 64'(LAT));
        chk("snap.idx",         64'(bus.order_idx), 64'h2031);
        chk("snap.count",       64'(bus.order_count), 64'd4);
        chk("snap.busy_after",  64'(bus.busy), 64'd0);

        // Back-to-back: request in the cycle done is high is accepted.
        apply(vecs[6]);
        run_sort("b2b_a", lat);
        apply(vecs[4]);
        run_sort("b2b_b", lat);
        chk("b2b_b.idx", 64'(bus.order_idx), vecs[4].exp_idx);

        // Full bucket, then abort by reset during PLACE.
        apply(vecs[3]);
        run_sort("abort_pre", lat);
        chk("abort_pre.idx", 64'(bus.order_idx), vecs[3].exp_idx);
        apply(vecs[1]);
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort.busy",  64'(bus.busy), 64'd0);
        chk("abort.done",  64'(bus.done), 64'd0);
        chk("abort.valid", 64'(bus.list_valid), 64'd0);
        chk("abort.count", 64'(bus.order_count), 64'd0);
        chk("abort.idx",   64'(bus.order_idx), 64'd0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.idle_busy", 64'(bus.busy), 64'd0);
        run_sort("post_abort", lat);
        chk("post_abort.idx",   64'(bus.order_idx), 64'h2031);
        chk("post_abort.count", 64'(bus.order_count), 64'd4);
        chk("post_abort.valid", 64'(bus.list_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
